// File: rtl/regfile_sequencer_if.sv
// regfile_sequencer_if: command, register-file and response signals of the sequencer
interface regfile_sequencer_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [3:0] cmd_dst;
    logic [3:0] cmd_srcA;
    logic [3:0] cmd_srcB;
    logic [7:0] cmd_imm;
    logic [3:0] A_sel;
    logic [3:0] B_sel;
    logic [7:0] A;
    logic [7:0] B;
    logic       writeEnable;
    logic [3:0] replaceSel;
    logic [7:0] replaceData;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic       rsp_carry;

    modport slave (
        input  cmd_valid, cmd_op, cmd_dst, cmd_srcA, cmd_srcB, cmd_imm, A, B, rsp_ready,
        output cmd_ready, A_sel, B_sel, writeEnable, replaceSel, replaceData, rsp_valid, rsp_data, rsp_carry
    );

    modport master (
        output cmd_valid, cmd_op, cmd_dst, cmd_srcA, cmd_srcB, cmd_imm, A, B, rsp_ready,
        input  cmd_ready, A_sel, B_sel, writeEnable, replaceSel, replaceData, rsp_valid, rsp_data, rsp_carry
    );
endinterface

// File: rtl/regfile_sequencer.sv
// regfile_sequencer: executes LOADI/READ/ADD/MOVE commands against an external register file
module regfile_sequencer (
    input logic               clk,
    input logic               rst,
    regfile_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, FETCH, WRITE, RESP} state_t;

    localparam logic [1:0] OP_LOADI = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_ADD   = 2'b10;

    state_t     state, state_nxt;
    logic [1:0] op;
    logic [3:0] dst, src_a, src_b;
    logic [7:0] imm, result;
    logic       carry;
    logic [8:0] sum;

    assign sum = {1'b0, bus.A} + {1'b0, bus.B};

    // state register; async reset aborts any command in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // latch the command on accept and capture the result at the end of FETCH
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op     <= '0;
            dst    <= '0;
            src_a  <= '0;
            src_b  <= '0;
            imm    <= '0;
            result <= '0;
            carry  <= 1'b0;
        end else begin
            if (state == IDLE && bus.cmd_valid) begin
                op    <= bus.cmd_op;
                dst   <= bus.cmd_dst;
                src_a <= bus.cmd_srcA;
                src_b <= bus.cmd_srcB;
                imm   <= bus.cmd_imm;
            end
            if (state == FETCH) begin
                result <= op == OP_LOADI ? imm : op == OP_ADD ? sum[7:0] : bus.A;
                carry  <= op == OP_ADD && sum[8];
            end
        end
    end

    // next-state: READ skips the write cycle, RESP waits for the consumer
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = bus.cmd_valid ? FETCH : IDLE;
            FETCH:   state_nxt = op == OP_READ ? RESP : WRITE;
            WRITE:   state_nxt = RESP;
            default: state_nxt = bus.rsp_ready ? IDLE : RESP;
        endcase
    end

    assign bus.cmd_ready   = state == IDLE;
    assign bus.writeEnable = state == WRITE;
    assign bus.rsp_valid   = state == RESP;
    assign bus.A_sel       = src_a;
    assign bus.B_sel       = src_b;
    assign bus.replaceSel  = dst;
    assign bus.replaceData = result;
    assign bus.rsp_data    = result;
    assign bus.rsp_carry   = carry;
endmodule

// File: tb/tb_regfile_sequencer.sv
// tb_regfile_sequencer: directed self-checking bench with a behavioural register file
module tb_regfile_sequencer;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   wr_cnt = 0;
    logic [3:0] wr_sel;
    logic [7:0] wr_data;
    logic [7:0] rf [16];

    regfile_sequencer_if bus();
    regfile_sequencer dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    assign bus.A = rf[bus.A_sel];
    assign bus.B = rf[bus.B_sel];

    // register file and write monitor
    always @(posedge clk) begin
        if (bus.writeEnable) begin
            rf[bus.replaceSel] <= bus.replaceData;
            wr_cnt  <= wr_cnt + 1;
            wr_sel  <= bus.replaceSel;
            wr_data <= bus.replaceData;
        end
    end

    task automatic issue(input logic [1:0] op, input logic [3:0] dst, input logic [3:0] sa, input logic [3:0] sb,
                         input logic [7:0] imm, output int lat, output logic [7:0] d, output logic c,
                         output int nw, output logic [3:0] ws, output logic [7:0] wd);
        int w0;
        w0 = wr_cnt;
        bus.cmd_op = op;
        bus.cmd_dst = dst;
        bus.cmd_srcA = sa;
        bus.cmd_srcB = sb;
        bus.cmd_imm = imm;
        bus.cmd_valid = 1'b1;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        lat = 1;
        while (bus.rsp_valid !== 1'b1 && lat < 8) begin
            @(posedge clk); #1;
            lat++;
        end
        d = bus.rsp_data;
        c = bus.rsp_carry;
        nw = wr_cnt - w0;
        ws = wr_sel;
        wd = wr_data;
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_cmd_ready: got %b want 1", bus.cmd_ready); end
        checks++; if (bus.writeEnable !== 1'b0) begin errors++; $display("FAIL rst_we: got %b want 0", bus.writeEnable); end
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid: got %b want 0", bus.rsp_valid); end
        checks++; if ({bus.rsp_data, bus.rsp_carry} !== 9'h0) begin errors++; $display("FAIL rst_rsp: got %h/%b want 00/0", bus.rsp_data, bus.rsp_carry); end
        checks++; if ({bus.A_sel, bus.B_sel, bus.replaceSel, bus.replaceData} !== 20'h0) begin errors++; $display("FAIL rst_sel: got %h %h %h %h want 0", bus.A_sel, bus.B_sel, bus.replaceSel, bus.replaceData); end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_loadi();
        int lat, nw; logic [7:0] d, wd; logic c; logic [3:0] ws;
        issue(2'b00, 4'd3, 4'd0, 4'd0, 8'h5A, lat, d, c, nw, ws, wd);
        checks++; if (lat !== 3) begin errors++; $display("FAIL loadi_lat: got %0d want 3", lat); end
        checks++; if (d !== 8'h5A) begin errors++; $display("FAIL loadi_data: got %h want 5a", d); end
        checks++; if (nw !== 1 || ws !== 4'd3 || wd !== 8'h5A) begin errors++; $display("FAIL loadi_write: got n=%0d sel=%0d data=%h want n=1 sel=3 data=5a", nw, ws, wd); end
    endtask

    task automatic test_add();
        int lat, nw; logic [7:0] d, wd; logic c; logic [3:0] ws;
        issue(2'b00, 4'd1, 4'd0, 4'd0, 8'hF0, lat, d, c, nw, ws, wd);
        issue(2'b00, 4'd2, 4'd0, 4'd0, 8'h20, lat, d, c, nw, ws, wd);
        issue(2'b10, 4'd4, 4'd1, 4'd2, 8'h00, lat, d, c, nw, ws, wd);
        checks++; if (lat !== 3) begin errors++; $display("FAIL add_lat: got %0d want 3", lat); end
        checks++; if (d !== 8'h10 || c !== 1'b1) begin errors++; $display("FAIL add_rsp: got %h/%b want 10/1", d, c); end
        checks++; if (nw !== 1 || ws !== 4'd4 || wd !== 8'h10) begin errors++; $display("FAIL add_write: got n=%0d sel=%0d data=%h want n=1 sel=4 data=10", nw, ws, wd); end
        issue(2'b01, 4'd0, 4'd4, 4'd0, 8'h00, lat, d, c, nw, ws, wd);
        checks++; if (lat !== 2) begin errors++; $display("FAIL read_lat: got %0d want 2", lat); end
        checks++; if (d !== 8'h10 || c !== 1'b0) begin errors++; $display("FAIL read_rsp: got %h/%b want 10/0", d, c); end
        checks++; if (nw !== 0) begin errors++; $display("FAIL read_nowrite: got %0d writes want 0", nw); end
    endtask

    task automatic test_hold();
        int lat, nw; logic [7:0] d, wd; logic c; logic [3:0] ws;
        issue(2'b00, 4'd7, 4'd0, 4'd0, 8'h77, lat, d, c, nw, ws, wd);
        bus.cmd_op = 2'b01;
        bus.cmd_srcA = 4'd7;
        bus.cmd_valid = 1'b1;
        @(posedge clk); #1;
        bus.cmd_op = 2'b00;
        bus.cmd_dst = 4'd8;
        bus.cmd_imm = 8'h88;
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 8'h77) begin errors++; $display("FAIL hold_rsp%0d: got %b/%h want 1/77", i, bus.rsp_valid, bus.rsp_data); end
            checks++; if (bus.cmd_ready !== 1'b0 || bus.A_sel !== 4'd7) begin errors++; $display("FAIL hold_ctl%0d: got ready=%b asel=%0d want 0/7", i, bus.cmd_ready, bus.A_sel); end
            @(posedge clk); #1;
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        checks++; if (bus.cmd_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL hold_release: got ready=%b valid=%b want 1/0", bus.cmd_ready, bus.rsp_valid); end
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        checks++; if (bus.cmd_ready !== 1'b0) begin errors++; $display("FAIL hold_accept: got ready=%b want 0", bus.cmd_ready); end
        @(posedge clk); #1;
        checks++; if (bus.writeEnable !== 1'b1 || bus.replaceSel !== 4'd8 || bus.replaceData !== 8'h88) begin errors++; $display("FAIL hold_second_write: got %b %0d %h want 1 8 88", bus.writeEnable, bus.replaceSel, bus.replaceData); end
        @(posedge clk); #1;
        checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 8'h88) begin errors++; $display("FAIL hold_second_rsp: got %b/%h want 1/88", bus.rsp_valid, bus.rsp_data); end
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_move();
        int lat, nw; logic [7:0] d, wd; logic c; logic [3:0] ws;
        issue(2'b00, 4'd5, 4'd0, 4'd0, 8'h33, lat, d, c, nw, ws, wd);
        issue(2'b10, 4'd6, 4'd1, 4'd2, 8'h00, lat, d, c, nw, ws, wd);
        issue(2'b11, 4'd5, 4'd5, 4'd0, 8'h00, lat, d, c, nw, ws, wd);
        checks++; if (lat !== 3) begin errors++; $display("FAIL move_lat: got %0d want 3", lat); end
        checks++; if (d !== 8'h33 || c !== 1'b0) begin errors++; $display("FAIL move_rsp: got %h/%b want 33/0", d, c); end
        checks++; if (nw !== 1 || ws !== 4'd5 || wd !== 8'h33) begin errors++; $display("FAIL move_write: got n=%0d sel=%0d data=%h want n=1 sel=5 data=33", nw, ws, wd); end
    endtask

    task automatic test_rst_write();
        int lat, nw, w0; logic [7:0] d, wd; logic c; logic [3:0] ws;
        issue(2'b00, 4'd9, 4'd0, 4'd0, 8'h11, lat, d, c, nw, ws, wd);
        w0 = wr_cnt;
        bus.cmd_op = 2'b00;
        bus.cmd_dst = 4'd9;
        bus.cmd_imm = 8'hC3;
        bus.cmd_valid = 1'b1;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        @(posedge clk); #1;
        checks++; if (bus.writeEnable !== 1'b1) begin errors++; $display("FAIL abort_we_before: got %b want 1", bus.writeEnable); end
        #2 rst = 1'b1;
        #1;
        checks++; if (bus.writeEnable !== 1'b0 || bus.cmd_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL abort_ctl: got we=%b ready=%b valid=%b want 0/1/0", bus.writeEnable, bus.cmd_ready, bus.rsp_valid); end
        checks++; if ({bus.rsp_data, bus.replaceData, bus.replaceSel, bus.A_sel} !== 24'h0) begin errors++; $display("FAIL abort_data: got %h %h %h %h want 0", bus.rsp_data, bus.replaceData, bus.replaceSel, bus.A_sel); end
        repeat (2) @(posedge clk);
        #1;
        checks++; if (wr_cnt !== w0) begin errors++; $display("FAIL abort_nowrite: got %0d writes want 0", wr_cnt - w0); end
        rst = 1'b0;
        issue(2'b01, 4'd0, 4'd9, 4'd0, 8'h00, lat, d, c, nw, ws, wd);
        checks++; if (lat !== 2 || d !== 8'h11) begin errors++; $display("FAIL abort_after: got lat=%0d data=%h want 2/11", lat, d); end
    endtask

    task automatic test_back_to_back();
        int lat, nw, w0; logic [7:0] d, wd; logic c; logic [3:0] ws;
        w0 = wr_cnt;
        for (int i = 0; i < 16; i++) issue(2'b00, 4'(i), 4'd0, 4'd0, 8'(i), lat, d, c, nw, ws, wd);
        checks++; if (wr_cnt - w0 !== 16) begin errors++; $display("FAIL b2b_writes: got %0d want 16", wr_cnt - w0); end
        w0 = wr_cnt;
        for (int i = 0; i < 16; i++) begin
            issue(2'b01, 4'd0, 4'(i), 4'd0, 8'h00, lat, d, c, nw, ws, wd);
            checks++; if (d !== 8'(i) || lat !== 2) begin errors++; $display("FAIL b2b_read%0d: got data=%h lat=%0d want %h/2", i, d, lat, 8'(i)); end
        end
        checks++; if (wr_cnt !== w0) begin errors++; $display("FAIL b2b_stray_we: got %0d writes want 0", wr_cnt - w0); end
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_op = 2'b00;
        bus.cmd_dst = 4'd0;
        bus.cmd_srcA = 4'd0;
        bus.cmd_srcB = 4'd0;
        bus.cmd_imm = 8'h00;
        bus.rsp_ready = 1'b0;
        test_reset();
        test_loadi();
        test_add();
        test_hold();
        test_move();
        test_rst_write();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
